ysyx_axi_rr_arbiter: RTL and testbench



---
 rtl/ysyx_axi_rr_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_axi_rr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_axi_rr_arbiter.sv
// ysyx_axi_rr_arbiter: round-robin N-read / 1-write arbiter onto one 64-bit AXI4 master, one transaction in flight.
// Optional local mtime window enabled by defining YSYX_ARB_CLINT_EN.
module ysyx_axi_rr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int N_RD = 2,
  parameter logic [ADDR_W-1:0] RTC_ADDR = ADDR_W'(32'h0200_BFF8)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD-1:0]        rd_valid,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  input  logic [N_RD*3-1:0]      rd_size,
  output logic [N_RD-1:0]        rd_resp_valid,
  output logic [31:0]            rd_resp_data,
  output logic                   rd_resp_err,
  input  logic                   wr_valid,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [31:0]            wr_data,
  input  logic [3:0]             wr_strb,
  output logic                   wr_resp_valid,
  output logic                   wr_resp_err,
  output logic [ADDR_W-1:0]      io_master_araddr,
  output logic                   io_master_arvalid,
  input  logic                   io_master_arready,
  output logic [3:0]             io_master_arid,
  output logic [7:0]             io_master_arlen,
  output logic [2:0]             io_master_arsize,
  output logic [1:0]             io_master_arburst,
  input  logic [63:0]            io_master_rdata,
  input  logic [1:0]             io_master_rresp,
  input  logic                   io_master_rlast,
  input  logic [3:0]             io_master_rid,
  input  logic                   io_master_rvalid,
  output logic                   io_master_rready,
  output logic [ADDR_W-1:0]      io_master_awaddr,
  output logic                   io_master_awvalid,
  input  logic                   io_master_awready,
  output logic [3:0]             io_master_awid,
  output logic [7:0]             io_master_awlen,
  output logic [2:0]             io_master_awsize,
  output logic [1:0]             io_master_awburst,
  output logic [63:0]            io_master_wdata,
  output logic [7:0]             io_master_wstrb,
  output logic                   io_master_wlast,
  output logic                   io_master_wvalid,
  input  logic                   io_master_wready,
  input  logic [1:0]             io_master_bresp,
  input  logic [3:0]             io_master_bid,
  input  logic                   io_master_bvalid,
  output logic                   io_master_bready
);
  localparam int IW = N_RD > 1 ? $clog2(N_RD) : 1;
  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, DONE} state_t;
  state_t st, nxt;
  logic [IW-1:0] g, rr_ptr, pick;
  logic [ADDR_W-1:0] addr, pa;
  logic [31:0] wdat, rdat, lane, local_data;
  logic [3:0] strb, s;
  logic [2:0] size, wsize;
  logic found, take_wr, take_rd, local_rd, is_wr, last_wr, aw_done, w_done, err, aw_hs, w_hs;
  // Two passes give the first requester strictly after rr_ptr, wrapping around to rr_ptr itself.
  always_comb begin
    found = 1'b0;
    pick = rr_ptr;
    for (int i = 0; i < N_RD; i++)
      if (!found && rd_valid[i] && IW'(i) > rr_ptr) begin
        found = 1'b1;
        pick = IW'(i);
      end
    for (int i = 0; i < N_RD; i++)
      if (!found && rd_valid[i] && IW'(i) <= rr_ptr) begin
        found = 1'b1;
        pick = IW'(i);
      end
  end
  assign take_wr = wr_valid && (!found || !last_wr);
  assign take_rd = found && !take_wr;
  assign pa = rd_addr[pick*ADDR_W +: ADDR_W];
  assign wsize = wr_strb == 4'h1 ? 3'd0 : wr_strb == 4'h3 ? 3'd1 : wr_strb == 4'hf ? 3'd2 : 3'd0;
`ifdef YSYX_ARB_CLINT_EN
  logic [63:0] mtime;
  logic unused_ok;
  always_ff @(posedge clk or posedge rst)
    if (rst) mtime <= '0;
    else mtime <= mtime + 64'd1;
  assign local_rd = pa == RTC_ADDR || pa == RTC_ADDR + ADDR_W'(4);
  assign local_data = pa == RTC_ADDR ? mtime[31:0] : mtime[63:32];
  assign unused_ok = ^{io_master_rid, io_master_bid};
`else
  logic unused_ok;
  assign local_rd = 1'b0;
  assign local_data = '0;
  assign unused_ok = ^{io_master_rid, io_master_bid, RTC_ADDR};
`endif
  assign aw_hs = io_master_awvalid && io_master_awready;
  assign w_hs = io_master_wvalid && io_master_wready;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = take_wr ? AW_W : take_rd ? (local_rd ? DONE : AR) : IDLE;
      AR:      nxt = io_master_arready ? R : AR;
      R:       nxt = io_master_rvalid && io_master_rlast ? DONE : R;
      AW_W:    nxt = (aw_done || aw_hs) && (w_done || w_hs) ? B : AW_W;
      B:       nxt = io_master_bvalid ? DONE : B;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      g <= '0;
      rr_ptr <= IW'(N_RD - 1);
      addr <= '0;
      size <= '0;
      wdat <= '0;
      strb <= '0;
      rdat <= '0;
      err <= 1'b0;
      is_wr <= 1'b0;
      last_wr <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && take_wr) begin
        is_wr <= 1'b1;
        last_wr <= 1'b1;
        addr <= wr_addr;
        wdat <= wr_data;
        strb <= wr_strb;
        size <= wsize;
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (st == IDLE && take_rd) begin
        is_wr <= 1'b0;
        last_wr <= 1'b0;
        g <= pick;
        addr <= pa;
        size <= rd_size[pick*3 +: 3];
        rdat <= local_data;
        err <= 1'b0;
        if (local_rd) rr_ptr <= pick;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (st == R && io_master_rvalid && io_master_rlast) begin
        rdat <= lane >> {addr[1:0], 3'b000};
        err <= io_master_rresp != 2'b00;
        rr_ptr <= g;
      end
      if (st == B && io_master_bvalid) err <= io_master_bresp != 2'b00;
    end
  end
  assign lane = addr[2] ? io_master_rdata[63:32] : io_master_rdata[31:0];
  assign s = strb << addr[1:0];
  assign io_master_araddr = addr;
  assign io_master_arvalid = st == AR;
  assign io_master_arid = 4'(g);
  assign io_master_arlen = 8'd0;
  assign io_master_arsize = size;
  assign io_master_arburst = 2'b01;
  assign io_master_rready = st == R;
  assign io_master_awaddr = addr;
  assign io_master_awvalid = st == AW_W && !aw_done;
  assign io_master_awid = 4'd0;
  assign io_master_awlen = 8'd0;
  assign io_master_awsize = size;
  assign io_master_awburst = 2'b01;
  assign io_master_wdata = {2{wdat << {addr[1:0], 3'b000}}};
  assign io_master_wstrb = addr[2] ? {s, 4'h0} : {4'h0, s};
  assign io_master_wlast = 1'b1;
  assign io_master_wvalid = st == AW_W && !w_done;
  assign io_master_bready = st == B;
  assign rd_resp_valid = st == DONE && !is_wr ? N_RD'(1) << g : '0;
  assign wr_resp_valid = st == DONE && is_wr;
  assign rd_resp_data = rdat;
  assign rd_resp_err = err;
  assign wr_resp_err = err;
endmodule

// File: tb/tb_ysyx_axi_rr_arbiter.sv
// tb_ysyx_axi_rr_arbiter: directed and randomized bench with an AXI slave and a transaction-level arbitration model.
module tb_ysyx_axi_rr_arbiter;
  localparam int N = 2;
  localparam logic [31:0] RTC = 32'h0200_BFF8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] rd_valid = '0;
  logic [N*32-1:0] rd_addr = '0;
  logic [N*3-1:0] rd_size = '0;
  logic [N-1:0] rd_resp_valid;
  logic [31:0] rd_resp_data;
  logic rd_resp_err;
  logic wr_valid = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0] wr_strb = '0;
  logic wr_resp_valid, wr_resp_err;
  logic [31:0] araddr, awaddr;
  logic arvalid, awvalid, rready, wvalid, wlast, bready;
  logic arready = 1'b0, awready = 1'b0, wready = 1'b0, rvalid = 1'b0, rlast = 1'b0, bvalid = 1'b0;
  logic [3:0] arid, awid;
  logic [3:0] rid = '0, bid = '0;
  logic [7:0] arlen, awlen, wstrb;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  logic [1:0] rresp = '0, bresp = '0;
  logic [63:0] rdata = '0, wdata;
  logic [3:0] strbs [6] = '{4'h1, 4'h3, 4'hf, 4'h2, 4'h6, 4'hc};
  int checks = 0, errors = 0, cyc = 0, m_ptr = N - 1, pulse_cyc = 0, req_cyc = 0, who = 0;
  bit m_lastwr = 1'b0;
  logic [63:0] exp_t;

  ysyx_axi_rr_arbiter #(.ADDR_W(32), .N_RD(N), .RTC_ADDR(RTC)) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_size(rd_size),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_resp_valid(wr_resp_valid), .wr_resp_err(wr_resp_err),
    .io_master_araddr(araddr), .io_master_arvalid(arvalid), .io_master_arready(arready),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_rdata(rdata), .io_master_rresp(rresp), .io_master_rlast(rlast), .io_master_rid(rid),
    .io_master_rvalid(rvalid), .io_master_rready(rready),
    .io_master_awaddr(awaddr), .io_master_awvalid(awvalid), .io_master_awready(awready),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_wdata(wdata), .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_wvalid(wvalid), .io_master_wready(wready),
    .io_master_bresp(bresp), .io_master_bid(bid), .io_master_bvalid(bvalid), .io_master_bready(bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [63:0] d);
    logic [31:0] l;
    l = a[2] ? d[63:32] : d[31:0];
    return l >> (8 * a[1:0]);
  endfunction

  function automatic logic [63:0] exp_wd(input logic [31:0] a, input logic [31:0] d);
    logic [63:0] r;
    int off;
    r = '0;
    off = int'(a[1:0]);
    for (int b = 0; b < 8; b++) if (b % 4 >= off) r[b*8 +: 8] = d[(b % 4 - off)*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] exp_ws(input logic [31:0] a, input logic [3:0] st);
    logic [7:0] r;
    int off;
    r = '0;
    off = int'(a[1:0]);
    for (int b = 0; b < 8; b++)
      if (b / 4 == int'(a[2]) && b % 4 >= off)
        if (st[b % 4 - off]) r[b] = 1'b1;
    return r;
  endfunction

  function automatic logic [2:0] exp_wsize(input logic [3:0] st);
    return st == 4'h1 ? 3'd0 : st == 4'h3 ? 3'd1 : st == 4'hf ? 3'd2 : 3'd0;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    rd_valid = '0;
    wr_valid = 1'b0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ptr = N - 1;
    m_lastwr = 1'b0;
  endtask

  task automatic set_rd(input int i, input logic [31:0] a, input logic [2:0] sz);
    rd_addr[i*32 +: 32] = a;
    rd_size[i*3 +: 3] = sz;
    rd_valid[i] = 1'b1;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    wr_addr = a;
    wr_data = d;
    wr_strb = st;
    wr_valid = 1'b1;
  endtask

  task automatic serve_next(input logic [63:0] d, input logic [1:0] resp, input int ad, input int wd,
                            input int bd, input int beats, input bit keep, output int w);
    int n, idx, mx;
    bit is_w;
    logic [31:0] a;
    idx = rr_pick(rd_valid, m_ptr);
    is_w = wr_valid && (idx < 0 || !m_lastwr);
    n = 0;
    while (!(arvalid || awvalid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("grant_timeout", 64'(n < 40), 64'(1));
    if (is_w) begin
      w = -1;
      m_lastwr = 1'b1;
      a = wr_addr;
      mx = ad > wd ? ad : wd;
      chk("ar_idle_on_wr", arvalid, 0);
      chk("awaddr", awaddr, a);
      chk("awsize", awsize, exp_wsize(wr_strb));
      chk("awlen", awlen, 0);
      chk("awburst", awburst, 1);
      chk("wdata", wdata, exp_wd(a, wr_data));
      chk("wstrb", wstrb, exp_ws(a, wr_strb));
      chk("wlast", wlast, 1);
      for (int i = 0; i <= mx; i++) begin
        chk("awvalid_hold", awvalid, 64'(i <= ad));
        chk("wvalid_hold", wvalid, 64'(i <= wd));
        awready = i == ad;
        wready = i == wd;
        @(negedge clk);
      end
      awready = 1'b0;
      wready = 1'b0;
      chk("b_bready", bready, 1);
      chk("b_awvalid", awvalid, 0);
      repeat (bd) @(negedge clk);
      bvalid = 1'b1;
      bresp = resp;
      @(negedge clk);
      bvalid = 1'b0;
      bresp = 2'b00;
      chk("wr_pulse", wr_resp_valid, 1);
      chk("wr_err", wr_resp_err, 64'(resp != 2'b00));
      chk("rd_pulse_on_wr", rd_resp_valid, 0);
      if (!keep) wr_valid = 1'b0;
    end else begin
      w = idx;
      m_lastwr = 1'b0;
      a = rd_addr[idx*32 +: 32];
      chk("aw_idle_on_rd", awvalid, 0);
      chk("araddr", araddr, a);
      chk("arsize", arsize, rd_size[idx*3 +: 3]);
      chk("arid", arid, idx);
      chk("arlen", arlen, 0);
      chk("arburst", arburst, 1);
      for (int i = 0; i < ad; i++) begin
        @(negedge clk);
        chk("arvalid_hold", arvalid, 1);
      end
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("r_rready", rready, 1);
      for (int b = 0; b < beats; b++) begin
        rvalid = 1'b1;
        rlast = 1'b0;
        rdata = {$urandom, $urandom};
        rresp = 2'b10;
        @(negedge clk);
      end
      rvalid = 1'b1;
      rlast = 1'b1;
      rdata = d;
      rresp = resp;
      @(negedge clk);
      rvalid = 1'b0;
      rlast = 1'b0;
      rresp = 2'b00;
      m_ptr = idx;
      pulse_cyc = cyc;
      chk("rd_pulse", rd_resp_valid, 64'(1) << idx);
      chk("rd_data", rd_resp_data, exp_rd(a, d));
      chk("rd_err", rd_resp_err, 64'(resp != 2'b00));
      chk("wr_pulse_on_rd", wr_resp_valid, 0);
      if (!keep) rd_valid[idx] = 1'b0;
    end
    @(negedge clk);
    chk("rd_pulse_one_cycle", rd_resp_valid, 0);
    chk("wr_pulse_one_cycle", wr_resp_valid, 0);
  endtask

  initial begin
    do_reset();
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rd_pulse", rd_resp_valid, 0);
    chk("rst_wr_pulse", wr_resp_valid, 0);
    chk("rst_rdata", rd_resp_data, 0);
    chk("rst_wdata", wdata, 0);

    set_rd(0, 32'h8000_0004, 3'd2);
    req_cyc = cyc;
    serve_next(64'h1122_3344_5566_7788, 2'b00, 0, 0, 0, 0, 1'b0, who);
    chk("t1_grant", who, 0);
    chk("t1_latency_cycles", pulse_cyc - req_cyc + 1, 4);

    set_rd(1, 32'h8000_0010, 3'd2);
    for (int n = 0; n < 10 && !arvalid; n++) @(negedge clk);
    chk("mid_arvalid", arvalid, 1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("mid_rready", rready, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_rready", rready, 0);
    chk("async_rst_arvalid", arvalid, 0);
    do_reset();

    set_rd(0, {16'h8000, 16'($urandom)}, 3'd2);
    set_rd(1, {16'h8000, 16'($urandom)}, 3'd1);
    for (int k = 0; k < 4; k++) begin
      serve_next({$urandom, $urandom}, 2'b00, $urandom_range(2, 0), 0, 0, $urandom_range(1, 0), 1'b1, who);
      chk("alt_grant", who, k % 2);
    end
    rd_valid = '0;

    set_wr(32'h8000_0003, 32'h0000_00ab, 4'h1);
    chk("store_model_wstrb", exp_ws(wr_addr, wr_strb), 8'h08);
    serve_next('0, 2'b00, 3, 0, 1, 0, 1'b0, who);
    chk("store_grant", who, -1);

    do_reset();
    set_wr(32'h8000_0100, $urandom, 4'hf);
    set_rd(0, 32'h8000_0008, 3'd2);
    serve_next('0, 2'b00, 0, 1, 0, 0, 1'b1, who);
    chk("mix_first", who, -1);
    set_wr(32'h8000_0106, $urandom, 4'h3);
    serve_next({$urandom, $urandom}, 2'b00, 1, 0, 0, 0, 1'b0, who);
    chk("mix_second", who, 0);
    serve_next('0, 2'b00, 0, 0, 2, 0, 1'b0, who);
    chk("mix_third", who, -1);

    set_rd(1, 32'h8000_0022, 3'd1);
    serve_next({$urandom, $urandom}, 2'b10, 0, 0, 0, 1, 1'b0, who);
    chk("slverr_grant", who, 1);
    set_rd(1, 32'h8000_0025, 3'd0);
    serve_next({$urandom, $urandom}, 2'b00, 0, 0, 0, 0, 1'b0, who);
    chk("clean_after_err", rd_resp_err, 0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        if (!rd_valid[i] && $urandom_range(1, 0) == 1) set_rd(i, {16'h8000, 16'($urandom)}, 3'($urandom_range(2, 0)));
      if (!wr_valid && $urandom_range(1, 0) == 1) set_wr({16'h8000, 16'($urandom)}, $urandom, strbs[$urandom_range(5, 0)]);
      if (rd_valid == '0 && !wr_valid) set_rd(0, {16'h8000, 16'($urandom)}, 3'd2);
      serve_next({$urandom, $urandom}, $urandom_range(3, 0) == 0 ? 2'b10 : 2'b00, $urandom_range(3, 0),
                 $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0), 1'($urandom_range(1, 0)), who);
    end

`ifdef YSYX_ARB_CLINT_EN
    do_reset();
    while (cyc < 100) @(negedge clk);
    set_rd(0, RTC, 3'd2);
    exp_t = 64'(cyc);
    @(negedge clk);
    chk("clint_no_ar", arvalid, 0);
    chk("clint_pulse", rd_resp_valid, 1);
    chk("clint_lo", rd_resp_data, exp_t[31:0]);
    chk("clint_err", rd_resp_err, 0);
    rd_valid = '0;
    @(negedge clk);
    set_rd(0, RTC + 32'd4, 3'd2);
    exp_t = 64'(cyc);
    @(negedge clk);
    chk("clint_hi_pulse", rd_resp_valid, 1);
    chk("clint_hi", rd_resp_data, exp_t[63:32]);
    rd_valid = '0;
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
